counter: RTL and testbench
==========================

Name: counter

Overview:
Parameterised synchronous up/down binary counter with enable, parallel load, and terminal-count flags. General-purpose block used as a cycle/event counter in datapath and control logic. Wraps modulo 2^WIDTH by default; saturation is a compile-time option.

Parameters:
WIDTH, 8, counter width in bits (legal 2..32)
RST_VAL, 0, value loaded into cnt on reset (must fit WIDTH bits)

Ports:
clk  input  1  rising-edge clock; all state updates on posedge clk
rst  input  1  synchronous reset, active-high
en  input  1  count enable; counter steps by one per cycle while high
up_dwn_n  input  1  direction: 1 = count up, 0 = count down
ld  input  1  synchronous parallel load strobe
ld_val  input  WIDTH  value loaded when ld = 1
cnt  output  WIDTH  registered count value
at_max  output  1  combinational: cnt == all-ones
at_min  output  1  combinational: cnt == 0
wrap  output  1  registered one-cycle pulse: previous update wrapped (or hit a rail, see Optional Feature)

Behaviour:
- Priority at each posedge clk: rst > ld > en > hold.
- rst = 1: cnt <= RST_VAL, wrap <= 0; all other inputs are ignored. Reset mid-count takes effect at the same edge.
- ld = 1 (rst = 0): cnt <= ld_val, wrap <= 0. en and up_dwn_n are ignored.
- en = 1, up_dwn_n = 1: cnt <= cnt + 1, modulo 2^WIDTH.
- en = 1, up_dwn_n = 0: cnt <= cnt - 1, modulo 2^WIDTH.
- en = 0: cnt holds its value; wrap <= 0.
- Latency: one cycle. A change of en or up_dwn_n is reflected in cnt at the next posedge. up_dwn_n may change on any cycle, including while en = 1; the sampled value is used.
- Wrap-around (default build):
  - up from all-ones gives 0, and wrap <= 1.
  - down from 0 gives all-ones, and wrap <= 1.
  - Otherwise wrap <= 0.
- at_max and at_min are decoded combinationally from cnt only; they do not depend on en or direction.
- No X propagation: all registers are defined after the first reset edge. Before the first reset, state is undefined.

Optional Feature:
Macro COUNTER_SATURATE_EN.
- Defined: counter saturates instead of wrapping. Up at all-ones holds all-ones; down at 0 holds 0. wrap pulses 1 for the cycle following an attempted step past the rail.
- Not defined: modulo wrap-around as in Behaviour.
- ld and rst behave identically in both builds.

Decomposition:
- Package counter_pkg holds:
  - localparam COUNTER_DEF_WIDTH = 8
  - typedef enum logic {CNT_DOWN = 1'b0, CNT_UP = 1'b1} cnt_dir_e, used for up_dwn_n decode
- Optional sub-module counter_next: purely combinational next-value and wrap computation (inputs cnt, en, up_dwn_n, ld, ld_val). The top holds only the registers.

Test Plan:
- Reset: rst = 1 for 1 cycle, with en = 0 and up_dwn_n = 1 -> cnt = 0, at_min = 1, wrap = 0.
- Count up: deassert rst on negedge; en = 1 for 5 posedges -> cnt = 1,2,3,4,5. Then en = 0 for 1 cycle -> cnt holds 5.
- Resume and reverse: en = 1 for 3 cycles up -> cnt = 8. Then up_dwn_n = 0 -> cnt = 7,6,5... each cycle down to 0.
- Wrap: from cnt = 0 count down once -> cnt = 255 (WIDTH = 8), wrap = 1 for one cycle. Count up once -> cnt = 0, wrap = 1. In the saturate build, both steps hold the rail value.
- Load/priority: ld = 1, ld_val = 8'hA5, en = 1 -> cnt = 8'hA5. Assert rst and ld together -> cnt = RST_VAL.
- Reset mid-count: en = 1, cnt = 0x40, rst = 1 -> cnt = 0 at that edge; counting resumes from 0 the cycle after rst = 0.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared width default and direction encoding for the counter
package counter_pkg;

    localparam int COUNTER_DEF_WIDTH = 8;

    typedef enum logic {
        CNT_DOWN = 1'b0,
        CNT_UP   = 1'b1
    } cnt_dir_e;

endpackage

// File: rtl/counter_next.sv
// rtl/counter_next.sv - combinational next-count and wrap/rail-hit computation
//
// Ports:
//   cnt      in   current registered count
//   en       in   count enable
//   up_dwn_n in   direction, 1 = up, 0 = down
//   ld       in   parallel load strobe (overrides en)
//   ld_val   in   value taken when ld = 1
//   cnt_nxt  out  value the count register takes at the next edge (reset excluded)
//   wrap_nxt out  value the wrap register takes at the next edge (reset excluded)
//
// Build option COUNTER_SATURATE_EN: hold at the rail instead of wrapping.
module counter_next
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_DEF_WIDTH
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic             en,
    input  logic             up_dwn_n,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] cnt_nxt,
    output logic             wrap_nxt
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    cnt_dir_e dir;
    assign dir = cnt_dir_e'(up_dwn_n);

    always_comb begin
        cnt_nxt  = cnt;
        wrap_nxt = 1'b0;
        if (ld) begin
            cnt_nxt = ld_val;
        end else if (en) begin
            case (dir)
                CNT_UP: begin
                    if (cnt == ALL_ONES) begin
                        // Stepping past the top rail: flag it in both builds.
                        wrap_nxt = 1'b1;
`ifdef COUNTER_SATURATE_EN
                        cnt_nxt  = ALL_ONES;
`else
                        cnt_nxt  = '0;
`endif
                    end else begin
                        cnt_nxt = cnt + ONE;
                    end
                end
                default: begin
                    if (cnt == '0) begin
                        wrap_nxt = 1'b1;
`ifdef COUNTER_SATURATE_EN
                        cnt_nxt  = '0;
`else
                        cnt_nxt  = ALL_ONES;
`endif
                    end else begin
                        cnt_nxt = cnt - ONE;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/counter.sv
// rtl/counter.sv - parameterised up/down counter with load and terminal-count flags
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous reset, active-high (highest priority)
//   en       in   count enable
//   up_dwn_n in   direction, 1 = up, 0 = down
//   ld       in   synchronous parallel load strobe
//   ld_val   in   load value
//   cnt      out  registered count
//   at_max   out  cnt is all-ones (combinational from cnt)
//   at_min   out  cnt is zero (combinational from cnt)
//   wrap     out  registered pulse: previous update wrapped or hit a rail
//
// Build option COUNTER_SATURATE_EN: saturate at the rails instead of wrapping.
module counter
    import counter_pkg::*;
#(
    parameter int               WIDTH   = COUNTER_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dwn_n,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] cnt,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap
);

    logic [WIDTH-1:0] cnt_nxt;
    logic             wrap_nxt;

    counter_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .cnt      (cnt),
        .en       (en),
        .up_dwn_n (up_dwn_n),
        .ld       (ld),
        .ld_val   (ld_val),
        .cnt_nxt  (cnt_nxt),
        .wrap_nxt (wrap_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= RST_VAL;
            wrap <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            wrap <= wrap_nxt;
        end
    end

    assign at_max = &cnt;
    assign at_min = ~|cnt;

endmodule

// File: tb/tb_counter.sv
// tb/tb_counter.sv - directed vector bench for counter (WIDTH 8, RST_VAL 0)
module tb_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up_dwn_n;
    logic       ld;
    logic [7:0] ld_val;
    logic [7:0] cnt;
    logic       at_max;
    logic       at_min;
    logic       wrap;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    counter #(
        .WIDTH   (8),
        .RST_VAL (8'h00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dwn_n (up_dwn_n),
        .ld       (ld),
        .ld_val   (ld_val),
        .cnt      (cnt),
        .at_max   (at_max),
        .at_min   (at_min),
        .wrap     (wrap)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       up;
        logic       ld;
        logic [7:0] ldv;
        logic [7:0] ec;
        logic       ew;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic e, logic u, logic l, logic [7:0] lv,
                                logic [7:0] ec, logic ew);
        vec_t v;
        v.rst = r; v.en = e; v.up = u; v.ld = l; v.ldv = lv; v.ec = ec; v.ew = ew;
        return v;
    endfunction

    // Drive one cycle of inputs on the falling edge, sample just after the rising edge.
    task automatic step(input logic r, input logic e, input logic u, input logic l,
                        input logic [7:0] lv);
        @(negedge clk);
        rst = r; en = e; up_dwn_n = u; ld = l; ld_val = lv;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] ec, input logic ew);
        logic emax;
        logic emin;
        emax = (ec == 8'hFF);
        emin = (ec == 8'h00);
        n_vec++;
        if (cnt !== ec || at_max !== emax || at_min !== emin || wrap !== ew) begin
            n_fail++;
            $display("FAIL %s: got cnt=%h max=%b min=%b wrap=%b, want cnt=%h max=%b min=%b wrap=%b",
                     name, cnt, at_max, at_min, wrap, ec, emax, emin, ew);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up_dwn_n = 1'b1; ld = 1'b0; ld_val = 8'h00;

        // reset, then count up 1..5, hold
        vecs.push_back(mk(1, 0, 1, 0, 8'h00, 8'h00, 0));
        for (int i = 1; i <= 5; i++)
            vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'(i), 0));
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h05, 0));
        // resume up to 8, then down to 0
        vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'h06, 0));
        vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'h07, 0));
        vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'h08, 0));
        for (int i = 7; i >= 0; i--)
            vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'(i), 0));
`ifdef COUNTER_SATURATE_EN
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h00, 1));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 0));
        vecs.push_back(mk(0, 0, 1, 1, 8'hFF, 8'hFF, 0));
        vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'hFF, 1));
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'hFF, 0));
`else
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'hFF, 1));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'hFF, 0));
        vecs.push_back(mk(0, 0, 1, 1, 8'hFF, 8'hFF, 0));
        vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'h00, 1));
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 0));
`endif
        // load beats en; reset beats load; counting resumes from RST_VAL
        vecs.push_back(mk(0, 1, 1, 1, 8'hA5, 8'hA5, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h3C, 8'h3C, 0));
        vecs.push_back(mk(1, 1, 1, 1, 8'h77, 8'h00, 0));
        vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'h01, 0));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].ld, vecs[i].ldv);
            check($sformatf("vec%0d", i), vecs[i].ec, vecs[i].ew);
        end

        // Reset mid-count at 0x40 with en held high
        step(0, 0, 1, 1, 8'h3F);
        check("mid_ld", 8'h3F, 0);
        step(0, 1, 1, 0, 8'h00);
        check("mid_up", 8'h40, 0);
        step(1, 1, 1, 0, 8'h00);
        check("mid_rst", 8'h00, 0);
        step(0, 1, 1, 0, 8'h00);
        check("mid_resume1", 8'h01, 0);
        step(0, 1, 1, 0, 8'h00);
        check("mid_resume2", 8'h02, 0);

        // Continuous down-count through zero: wrap must be a single-cycle pulse
        step(0, 0, 0, 1, 8'h01);
        check("wr_ld", 8'h01, 0);
        step(0, 1, 0, 0, 8'h00);
        check("wr_zero", 8'h00, 0);
`ifdef COUNTER_SATURATE_EN
        step(0, 1, 0, 0, 8'h00);
        check("wr_rail1", 8'h00, 1);
        step(0, 1, 0, 0, 8'h00);
        check("wr_rail2", 8'h00, 1);
        step(0, 1, 1, 0, 8'h00);
        check("wr_leave", 8'h01, 0);
`else
        step(0, 1, 0, 0, 8'h00);
        check("wr_under", 8'hFF, 1);
        step(0, 1, 0, 0, 8'h00);
        check("wr_next", 8'hFE, 0);
        // direction flip while enabled, back up through all-ones
        step(0, 1, 1, 0, 8'h00);
        check("wr_flip", 8'hFF, 0);
        step(0, 1, 1, 0, 8'h00);
        check("wr_over", 8'h00, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
